// File: rtl/ss_mac_pkg.sv
// Shared types and width helpers for the stochastic-symbol MAC.
package ss_mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int rn_width(input int in_w, input int ss_w);
        return in_w - ss_w;
    endfunction

    // A single channel still needs a 1-bit select port.
    function automatic int sel_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/ss_gen_param.sv
// Converts one binary sample into a stochastic symbol: upper bits plus a
// random round-up of the lower bits, clamped to the symbol range.
module ss_gen_param
    import ss_mac_pkg::*;
#(
    parameter int IN_W = 12,
    parameter int SS_W = 5
) (
    input  logic [IN_W-1:0]                    x,
    input  logic [rn_width(IN_W, SS_W)-1:0]    r,
    output logic [SS_W-1:0]                    s
);

    localparam int RN_W = rn_width(IN_W, SS_W);

    logic [SS_W:0] sum;

    assign sum = {1'b0, x[IN_W-1:RN_W]} + {{SS_W{1'b0}}, (x[RN_W-1:0] > r)};
    assign s   = sum[SS_W] ? {SS_W{1'b1}} : sum[SS_W-1:0];

endmodule

// File: rtl/ss_mac_param.sv
// Frame-based accumulator of stochastic symbols from one selected channel
// per beat, with saturation tracking and a valid/ready result handshake.
module ss_mac_param
    import ss_mac_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int IN_W  = 12,
    parameter int SS_W  = 5,
    parameter int ACC_W = 11,
    parameter int LEN_W = 8,
    localparam int RN_W  = rn_width(IN_W, SS_W),
    localparam int SEL_W = sel_width(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [LEN_W-1:0]       frame_len,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel,
    input  logic [N_CH*IN_W-1:0]   x_in,
    input  logic [N_CH*RN_W-1:0]   rand_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       acc_out,
    output logic                   sat_flag,
    output logic                   busy
);

    localparam logic [SEL_W:0] LAST_CH = (SEL_W+1)'(N_CH - 1);

    state_t             state_reg, state_next;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic               sat_reg, sat_next;
    logic [LEN_W-1:0]   count_reg, count_next;
    logic [LEN_W-1:0]   len_reg, len_next;
    logic               mode_reg, mode_next;
    logic [SEL_W-1:0]   ptr_reg, ptr_next;

    logic [SS_W-1:0]    sym [N_CH];
    logic [SEL_W-1:0]   idx;
    logic [SS_W-1:0]    sym_sel;
    logic [ACC_W:0]     sum;
    logic [LEN_W-1:0]   count_inc;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_gen
            ss_gen_param #(
                .IN_W (IN_W),
                .SS_W (SS_W)
            ) u_gen (
                .x (x_in[gi*IN_W +: IN_W]),
                .r (rand_in[gi*RN_W +: RN_W]),
                .s (sym[gi])
            );
        end
    endgenerate

    // Out-of-range fixed selections clamp to the last channel.
    always_comb begin
        idx = sel;
        if (mode_reg) begin
            idx = ptr_reg;
        end else if ({1'b0, sel} > LAST_CH) begin
            idx = LAST_CH[SEL_W-1:0];
        end
    end

    assign sym_sel   = sym[idx];
    assign sum       = {1'b0, acc_reg} + (ACC_W+1)'(sym_sel);
    assign count_inc = count_reg + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            acc_reg   <= '0;
            sat_reg   <= 1'b0;
            count_reg <= '0;
            len_reg   <= '0;
            mode_reg  <= 1'b0;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            sat_reg   <= sat_next;
            count_reg <= count_next;
            len_reg   <= len_next;
            mode_reg  <= mode_next;
            ptr_reg   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        sat_next   = sat_reg;
        count_next = count_reg;
        len_next   = len_reg;
        mode_next  = mode_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    len_next   = frame_len;
                    mode_next  = mode;
                    acc_next   = '0;
                    sat_next   = 1'b0;
                    count_next = '0;
                    ptr_next   = '0;
                    state_next = (frame_len == '0) ? ST_DONE : ST_ACC;
                end
            end
            ST_ACC: begin
                if (in_valid) begin
                    acc_next   = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
                    sat_next   = sat_reg | sum[ACC_W];
                    count_next = count_inc;
                    ptr_next   = ({1'b0, ptr_reg} == LAST_CH) ? '0 : ptr_reg + 1'b1;
                    if (count_inc == len_reg) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign in_ready  = (state_reg == ST_ACC);
    assign out_valid = (state_reg == ST_DONE);
    assign busy      = (state_reg != ST_IDLE);
    assign acc_out   = acc_reg;
    assign sat_flag  = sat_reg;

endmodule

// File: doc/ss_mac_param.md
SS_MAC_PARAM -- requirements
Module: ss_mac_param

Interface
REQ-001 SHALL have parameter N_CH, default 8: number of input channels.
REQ-002 SHALL have parameter IN_W, default 12: binary input width per channel.
REQ-003 SHALL have parameter SS_W, default 5: stochastic-symbol width.
REQ-004 SHALL have parameter ACC_W, default 11: accumulator/result width.
REQ-005 SHALL have parameter LEN_W, default 8: frame-length counter width.
REQ-006 SHALL use derived constants RN_W = IN_W-SS_W (random width) and SEL_W = clog2(N_CH).
REQ-007 SHALL have port clk, input, 1: clock, rising-edge.
REQ-008 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-009 SHALL have port start, input, 1: frame start request.
REQ-010 SHALL have port frame_len, input, LEN_W: number of beats in the frame.
REQ-011 SHALL have port mode, input, 1: 0 = fixed channel via sel, 1 = round-robin.
REQ-012 SHALL have port sel, input, SEL_W: channel index in mode 0.
REQ-013 SHALL have port x_in, input, N_CH*IN_W: packed channel inputs, channel k at bits [k*IN_W +: IN_W].
REQ-014 SHALL have port rand_in, input, N_CH*RN_W: packed random numbers, same packing.
REQ-015 SHALL have ports in_valid (input, 1) and in_ready (output, 1): beat handshake.
REQ-016 SHALL have ports out_valid (output, 1) and out_ready (input, 1): result handshake.
REQ-017 SHALL have port acc_out, output, ACC_W: accumulated result.
REQ-018 SHALL have port sat_flag, output, 1: accumulator saturated during the current or last frame.
REQ-019 SHALL have port busy, output, 1: high whenever the FSM is not in IDLE.

Function
REQ-020 Symbol generation SHALL compute s = floor(x/2^RN_W) + (x mod 2^RN_W > r ? 1 : 0), saturated to 2^SS_W-1.
REQ-021 The FSM SHALL have states IDLE, ACC and DONE.
REQ-022 In IDLE, start=1 SHALL latch frame_len and mode, clear acc_out, sat_flag and the beat count, set the round-robin pointer to 0, and enter ACC (or DONE if frame_len=0).
REQ-023 In ACC, in_ready SHALL be 1; each in_valid&in_ready beat SHALL add the selected channel's symbol to acc_out and increment the beat count.
REQ-024 Mode 0 SHALL use live sel at each beat; sel>=N_CH SHALL select channel N_CH-1.
REQ-025 Mode 1 SHALL use the pointer, incrementing it per beat and wrapping from N_CH-1 to 0; sel SHALL be ignored.
REQ-026 Addition SHALL saturate at 2^ACC_W-1; a saturating beat SHALL set sat_flag, which stays set until the next start.
REQ-027 On the beat where count reaches the latched frame_len, the FSM SHALL enter DONE the next cycle, with the final acc_out visible in that same cycle (1-cycle latency).
REQ-028 In DONE, out_valid SHALL be 1 and acc_out/sat_flag SHALL be held; out_valid&out_ready SHALL return the FSM to IDLE.
REQ-029 start SHALL be ignored outside IDLE; in_valid SHALL be ignored outside ACC.
REQ-030 in_valid=0 in ACC SHALL stall with no state change.

Reset
REQ-031 rst=0 SHALL immediately force IDLE, with acc_out=0, sat_flag=0, count=0, pointer=0, in_ready=0, out_valid=0 and busy=0, including mid-frame.
REQ-032 The first frame after reset release SHALL require a fresh start.

Structure
REQ-033 Package ss_mac_pkg SHALL hold the state enum and the RN_W/SEL_W helper functions.
REQ-034 Sub-module ss_gen_param (IN_W, SS_W) SHALL implement REQ-020 and be instantiated N_CH times.
REQ-035 Channel select SHALL be a single N_CH:1 mux on the symbols; the accumulator SHALL be a single adder.

Verification
REQ-036 Mode 0, sel=0, x ch0=12'h100, rand=0, frame_len=4, in_valid held high -> acc_out=8, out_valid one cycle after the 4th beat, sat_flag=0.
REQ-037 x=12'h040: with rand=63 the symbol is 1; with rand=64 the symbol is 0. x=12'hFFF with rand=0 gives symbol 31 (clamped).
REQ-038 Mode 1, ch k = k*128, rand=0, frame_len=10 -> acc_out=29 (channel order 0..7,0,1).
REQ-039 Symbol 31 on every beat, frame_len=70 -> acc_out=2047 and sat_flag=1, set on beat 67.
REQ-040 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and acc_out stable, and start pulses are ignored.
REQ-041 Stall and reset: in_valid toggling mid-frame gives the same result as no stall; rst=0 at beat 3 -> all outputs 0, IDLE state.
